// File: rtl/microsequencer.sv
// Microsequencer: next-state select, return stack and state register for the microstore.
// Optional WAIT watchdog is enabled by defining MSEQ_WAIT_TIMEOUT_EN.
module microsequencer #(
  parameter int STATE_W     = 7,
  parameter int STACK_DEPTH = 4,
  parameter int WAIT_LIMIT  = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [2:0]                     ns_sel,
  input  logic                           inv,
  input  logic [1:0]                     cond_sel,
  input  logic [3:0]                     cond_in,
  input  logic [STATE_W-1:0]             cr_addr,
  input  logic [STATE_W-1:0]             enc_state,
  output logic [STATE_W-1:0]             currentState,
  output logic                           stack_err,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           wait_timeout
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [2:0] {
    NS_ENC  = 3'd0,
    NS_CALL = 3'd1,
    NS_JUMP = 3'd2,
    NS_INC  = 3'd3,
    NS_CBR  = 3'd4,
    NS_CENC = 3'd5,
    NS_WAIT = 3'd6,
    NS_RET  = 3'd7
  } ns_e;

  logic [STATE_W-1:0] stack_r [STACK_DEPTH];
  logic               c_s;
  logic [STATE_W-1:0] inc_s;
  logic [STATE_W-1:0] next_s;
  logic [SP_W-1:0]    sp_dec_s;
  logic               push_s;
  logic               pop_s;
  logic               err_s;
  logic               hold_s;
  logic               wd_fire_s;

  // Next-state decode plus stack push/pop requests for the current microinstruction.
  always_comb begin
    c_s      = cond_in[cond_sel] ^ inv;
    inc_s    = currentState + STATE_W'(1);
    sp_dec_s = sp - SP_W'(1);
    next_s   = inc_s;
    push_s   = 1'b0;
    pop_s    = 1'b0;
    err_s    = 1'b0;
    hold_s   = 1'b0;
    case (ns_e'(ns_sel))
      NS_ENC:  next_s = enc_state;
      NS_CALL: begin
        next_s = cr_addr;
        // A full stack still takes the jump; only the return address is lost.
        if (sp == SP_W'(STACK_DEPTH)) begin
          err_s = 1'b1;
        end else begin
          push_s = 1'b1;
        end
      end
      NS_JUMP: next_s = cr_addr;
      NS_INC:  next_s = inc_s;
      NS_CBR:  next_s = c_s ? cr_addr : inc_s;
      NS_CENC: next_s = c_s ? enc_state : inc_s;
      NS_WAIT: begin
        if (c_s) begin
          next_s = cr_addr;
        end else begin
          next_s = currentState;
          hold_s = 1'b1;
        end
      end
      NS_RET: begin
        if (sp == SP_W'(0)) begin
          next_s = {STATE_W{1'b0}};
          err_s  = 1'b1;
        end else begin
          next_s = stack_r[sp_dec_s[IDX_W-1:0]];
          pop_s  = 1'b1;
        end
      end
      default: next_s = inc_s;
    endcase
  end

  // State register, return stack and sticky stack-fault flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      currentState <= {STATE_W{1'b0}};
      sp           <= {SP_W{1'b0}};
      stack_err    <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= {STATE_W{1'b0}};
      end
    end else if (!stall) begin
      currentState <= wd_fire_s ? {STATE_W{1'b0}} : next_s;
      if (push_s) begin
        stack_r[sp[IDX_W-1:0]] <= inc_s;
        sp                     <= sp + SP_W'(1);
      end else if (pop_s) begin
        sp <= sp_dec_s;
      end else begin
        sp <= sp;
      end
      if (err_s) begin
        stack_err <= 1'b1;
      end else begin
        stack_err <= stack_err;
      end
    end else begin
      currentState <= currentState;
      sp           <= sp;
      stack_err    <= stack_err;
    end
  end

`ifdef MSEQ_WAIT_TIMEOUT_EN
  localparam int CNT_W = ($clog2(WAIT_LIMIT + 1) < 4) ? 4 : $clog2(WAIT_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt_r;

  assign wd_fire_s = hold_s && (wait_cnt_r == CNT_W'(WAIT_LIMIT));

  // Watchdog: counts unstalled holding cycles, fires once the limit is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r   <= {CNT_W{1'b0}};
      wait_timeout <= 1'b0;
    end else if (!stall) begin
      if (wd_fire_s) begin
        wait_cnt_r   <= {CNT_W{1'b0}};
        wait_timeout <= 1'b1;
      end else if (hold_s) begin
        wait_cnt_r   <= wait_cnt_r + CNT_W'(1);
        wait_timeout <= wait_timeout;
      end else begin
        wait_cnt_r   <= {CNT_W{1'b0}};
        wait_timeout <= wait_timeout;
      end
    end else begin
      wait_cnt_r   <= wait_cnt_r;
      wait_timeout <= wait_timeout;
    end
  end
`else
  assign wd_fire_s    = hold_s & 1'b0;
  assign wait_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed plan items plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_microsequencer;

  localparam int DEPTH = 4;
  localparam int LIMIT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic [2:0] ns_sel = 3'd3;
  logic       inv = 1'b0;
  logic [1:0] cond_sel = 2'd0;
  logic [3:0] cond_in = 4'd0;
  logic [6:0] cr_addr = 7'd0;
  logic [6:0] enc_state = 7'd0;
  logic [6:0] currentState;
  logic       stack_err;
  logic [2:0] sp;
  logic       wait_timeout;

  microsequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .ns_sel(ns_sel), .inv(inv),
    .cond_sel(cond_sel), .cond_in(cond_in), .cr_addr(cr_addr), .enc_state(enc_state),
    .currentState(currentState), .stack_err(stack_err), .sp(sp), .wait_timeout(wait_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int m_state;
  int m_q[$];
  bit m_err;
  bit m_to;
  int m_hold;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("state", int'(currentState), m_state);
      chk("sp", int'(sp), m_q.size());
      chk("stack_err", int'(stack_err), int'(m_err));
      chk("wait_timeout", int'(wait_timeout), int'(m_to));
    end
  end

  function automatic void model_step();
    int c, inc, nxt;
    bit holding;
    c = int'(cond_in[cond_sel]) ^ int'(inv);
    inc = (m_state + 1) % 128;
    nxt = m_state;
    holding = 1'b0;
    if (stall) return;
    case (ns_sel)
      3'd0: nxt = enc_state;
      3'd1: begin
        nxt = cr_addr;
        if (m_q.size() == DEPTH) m_err = 1'b1;
        else m_q.push_back(inc);
      end
      3'd2: nxt = cr_addr;
      3'd3: nxt = inc;
      3'd4: nxt = c ? int'(cr_addr) : inc;
      3'd5: nxt = c ? int'(enc_state) : inc;
      3'd6: begin
        nxt = c ? int'(cr_addr) : m_state;
        holding = (c == 0);
      end
      default: begin
        if (m_q.size() == 0) begin
          nxt = 0;
          m_err = 1'b1;
        end else begin
          nxt = m_q.pop_back();
        end
      end
    endcase
`ifdef MSEQ_WAIT_TIMEOUT_EN
    if (holding) begin
      if (m_hold == LIMIT) begin
        nxt = 0;
        m_to = 1'b1;
        m_hold = 0;
      end else begin
        m_hold++;
      end
    end else begin
      m_hold = 0;
    end
`endif
    m_state = nxt;
  endfunction

  // One clock: drive fields at the falling edge, update the model at the rising edge
  task automatic cyc(input bit st, input int ns, input bit iv, input int cs,
                     input int ci, input int cr, input int enc);
    stall = st; ns_sel = 3'(ns); inv = iv; cond_sel = 2'(cs);
    cond_in = 4'(ci); cr_addr = 7'(cr); enc_state = 7'(enc);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("async_reset_state", int'(currentState), 0);
    chk("async_reset_sp", int'(sp), 0);
    chk("async_reset_err", int'(stack_err), 0);
    m_state = 0; m_q.delete(); m_err = 1'b0; m_to = 1'b0; m_hold = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;

    // Increment and wrap
    cyc(0, 2, 0, 0, 0, 126, 0);
    cyc(0, 3, 0, 0, 0, 0, 0);  chk("inc_127", int'(currentState), 127);
    cyc(0, 3, 0, 0, 0, 0, 0);  chk("inc_wrap", int'(currentState), 0);

    // Decode and conditional branch
    cyc(0, 2, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 12); chk("enc", int'(currentState), 12);
    cyc(0, 4, 0, 2, 4, 44, 0); chk("cbr_taken", int'(currentState), 44);
    cyc(0, 4, 1, 2, 4, 77, 0); chk("cbr_inv", int'(currentState), 45);

    // Call and return
    cyc(0, 2, 0, 0, 0, 20, 0);
    cyc(0, 1, 0, 0, 0, 50, 0); chk("call_state", int'(currentState), 50);
    chk("call_sp", int'(sp), 1);
    cyc(0, 2, 0, 0, 0, 53, 0);
    cyc(0, 7, 0, 0, 0, 0, 0);  chk("ret_state", int'(currentState), 21);
    chk("ret_sp", int'(sp), 0);

    // Stack overflow and underflow
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 10 + i, 0);
    chk("ovf_sp", int'(sp), 4);
    chk("ovf_err", int'(stack_err), 1);
    chk("ovf_state", int'(currentState), 14);
    do_reset();
    cyc(0, 7, 0, 0, 0, 0, 0);  chk("unf_state", int'(currentState), 0);
    chk("unf_err", int'(stack_err), 1);
    do_reset();

    // Memory wait with a stall in the middle
    cyc(0, 1, 0, 0, 0, 9, 0);
    for (int i = 0; i < 3; i++) cyc(0, 6, 0, 0, 0, 4, 0);
    chk("wait_hold", int'(currentState), 9);
    cyc(1, 7, 0, 0, 1, 4, 0);
    cyc(1, 7, 0, 0, 1, 4, 0);
    chk("stall_state", int'(currentState), 9);
    chk("stall_sp", int'(sp), 1);
    cyc(0, 6, 0, 0, 1, 4, 0);  chk("wait_exit", int'(currentState), 4);

    // Watchdog
    cyc(0, 2, 0, 0, 0, 9, 0);
`ifdef MSEQ_WAIT_TIMEOUT_EN
    for (int i = 0; i < LIMIT; i++) cyc(0, 6, 0, 0, 0, 4, 0);
    chk("wd_pre_state", int'(currentState), 9);
    chk("wd_pre_flag", int'(wait_timeout), 0);
    cyc(0, 6, 0, 0, 0, 4, 0);
    chk("wd_state", int'(currentState), 0);
    chk("wd_flag", int'(wait_timeout), 1);
`else
    for (int i = 0; i < 100; i++) cyc(0, 6, 0, 0, 0, 4, 0);
    chk("nowd_state", int'(currentState), 9);
    chk("nowd_flag", int'(wait_timeout), 0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7), 1'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 15),
            $urandom_range(0, 127), $urandom_range(0, 127));
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state logic and state register for the microprogrammed control unit. Each cycle it takes the sequencing fields of the current microinstruction, the opcode-encoder target and the datapath condition flags, and produces the 7-bit `currentState` that addresses the microstore. It supports a small return stack for shared micro-routines and a wait mode for memory handshakes. It sits directly upstream of the microstore and closes the control loop.

## Interface
- `STATE_W`, 7, width of the microstore state address
- `STACK_DEPTH`, 4, return-stack entries (power of two, 2..8)
- `WAIT_LIMIT`, 15, maximum cycles in a WAIT before the watchdog fires (used only with the macro)

- `clk` input 1: rising-edge clock
- `reset` input 1: asynchronous, active-low
- `stall` input 1: holds state and stack unchanged for this cycle
- `ns_sel` input 3: next-state select field of the current microinstruction
- `inv` input 1: inverts the selected condition
- `cond_sel` input 2: selects one bit of `cond_in`
- `cond_in` input 4: condition flags: [0] MOC, [1] branch-taken, [2] zero, [3] overflow
- `cr_addr` input 7: literal target address field
- `enc_state` input 7: decode target from the opcode encoder
- `currentState` output 7: registered microstore address
- `stack_err` output 1: sticky flag for return-stack overflow or underflow
- `sp` output clog2(STACK_DEPTH)+1: current stack occupancy
- `wait_timeout` output 1: sticky watchdog flag (tied 0 without the macro)

## Operation
- `c = cond_in[cond_sel] ^ inv`.
- `inc = currentState + 1`, computed mod 2^7, so 127 wraps to 0.
- `ns_sel` decode:
  - 0 ENC: `enc_state`.
  - 1 CALL: `cr_addr`; push `inc`.
  - 2 JUMP: `cr_addr`.
  - 3 INC: `inc`.
  - 4 CBR: `c` ? `cr_addr` : `inc`.
  - 5 CENC: `c` ? `enc_state` : `inc`.
  - 6 WAIT: `c` ? `cr_addr` : `currentState` (hold).
  - 7 RET: pop and return the top of stack.
- CALL when `sp == STACK_DEPTH`: the jump is still taken, the push is discarded, and `stack_err` is set.
- RET when `sp == 0`: next state is 0 (fetch), `sp` stays 0, and `stack_err` is set.
- The stack is LIFO. `sp` counts 0..STACK_DEPTH, and entries above `sp` are don't-care.
- `stall` = 1 freezes `currentState`, the stack, `sp` and the wait counter. Sticky flags keep their values.
- `stall` takes priority over every `ns_sel` action.
- Sticky flags clear only on `reset`.

## Timing
- On `reset` low, asynchronously:
  - `currentState` = 0
  - `sp` = 0
  - stack entries = 0
  - `stack_err` = 0
  - `wait_timeout` = 0
  - wait counter = 0
- After `reset` deasserts, the first rising edge evaluates the fields for state 0.
- Next state is combinational from the inputs and is registered on the rising edge of `clk`, giving one-cycle latency from microinstruction to new address.
- Push and pop take effect on the same edge as the state update. No same-cycle push and pop is possible.
- A WAIT with `c` already true leaves on the next edge, so it costs 1 cycle.
- Reset asserted mid-WAIT or mid-subroutine discards the stack and the counter.
- Inputs must be stable before the rising edge. The microstore output path is purely combinational.

## Configuration
- `MSEQ_WAIT_TIMEOUT_EN` defined:
  - A 4-bit or wider counter increments each unstalled cycle that WAIT holds.
  - It clears on any state change.
  - When it reaches `WAIT_LIMIT` while still holding, the next state is forced to 0, `wait_timeout` is set (sticky), and the counter clears.
- `MSEQ_WAIT_TIMEOUT_EN` undefined:
  - No counter is implemented and `wait_timeout` is constant 0.
  - WAIT holds indefinitely until `c` is true.

## Test plan
- Reset and increment: assert `reset` low mid-cycle, then check `currentState` = 0 immediately. Release reset and drive INC with `currentState` = 126 for two cycles, then check 127 followed by 0 (wrap).
- Decode and branch:
  - At state 1, ENC with `enc_state` = 12 gives 12.
  - CBR with `cond_sel` = 2, `cond_in` = 4'b0100, `inv` = 0, `cr_addr` = 44 gives 44.
  - Repeat with `inv` = 1: gives `inc`.
- Call/return: at state 20, CALL with `cr_addr` = 50 gives 50 and `sp` = 1. Then at state 53, RET gives 21 and `sp` = 0.
- Stack faults:
  - Five consecutive CALLs with `STACK_DEPTH` = 4 leave `sp` = 4 and set `stack_err`.
  - From reset, a RET gives 0 and sets `stack_err`.
- Memory wait:
  - WAIT with `cond_sel` = 0, MOC low for 3 cycles then high, `cr_addr` = 4: state holds for 3 edges, then 4.
  - With `stall` high for 2 cycles mid-wait, state and `sp` are unchanged.
- Watchdog (macro on, `WAIT_LIMIT` = 15): MOC held low. After 15 holding cycles, `currentState` = 0 and `wait_timeout` = 1. With the macro off, the state holds for 100 cycles and `wait_timeout` stays 0.
